// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - types and helpers shared by the fetch PC sequencer
`include "diagv2_const.vh"

package fetch_pc_unit_pkg;

    localparam int DATA_W  = `DataBusBits;
    localparam int ENTRY_W = `PredQEntryBits;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pred;
    } pq_entry_t;

    // Full-width compare covers both wrong direction and wrong target.
    function automatic logic mispredicted(input logic [DATA_W-1:0] pred,
                                          input logic [DATA_W-1:0] actual);
        return pred != actual;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch, resolve and predictor-update signal bundle
`include "diagv2_const.vh"

interface fetch_pc_unit_if;
    import fetch_pc_unit_pkg::*;

    logic              stall;
    logic [DATA_W-1:0] PCPrediction;
    logic [DATA_W-1:0] PC;
    logic              fetch_valid;
    logic              resolve_valid;
    logic              resolve_is_ctrl;
    logic              resolve_taken;
    logic [DATA_W-1:0] resolve_next_pc;
    logic              flush;
    logic              we;
    logic [DATA_W-1:0] PCUpdate;
    logic [DATA_W-1:0] targetUpdate;
    logic              takenUpdate;

    modport slave (
        input  stall, PCPrediction, resolve_valid, resolve_is_ctrl,
               resolve_taken, resolve_next_pc,
        output PC, fetch_valid, flush, we, PCUpdate, targetUpdate, takenUpdate
    );

    modport master (
        output stall, PCPrediction, resolve_valid, resolve_is_ctrl,
               resolve_taken, resolve_next_pc,
        input  PC, fetch_valid, flush, we, PCUpdate, targetUpdate, takenUpdate
    );

endinterface

// File: rtl/diagv2_const.vh
// rtl/diagv2_const.vh - shared bus widths and prediction-queue entry layout
`ifndef DIAGV2_CONST_VH
`define DIAGV2_CONST_VH

`define DataBusBits   64
`define PredQEntryBits (2*`DataBusBits)
`define PredQPcMsb    127
`define PredQPcLsb    64
`define PredQPredMsb  63
`define PredQPredLsb  0

`endif

// File: rtl/fetch_pc_unit_pred_queue.sv
// rtl/fetch_pc_unit_pred_queue.sv - circular FIFO of in-flight {pc, pred} entries
`include "diagv2_const.vh"

module pred_queue
    import fetch_pc_unit_pkg::*;
#(
    parameter int Q_DEPTH = 4,
    parameter int Q_PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               clear,
    output logic [ENTRY_W-1:0] head_data,
    output logic [Q_PTR_W:0]   count,
    output logic               full,
    output logic               empty
);

    localparam logic [Q_PTR_W:0] FULL_CNT = Q_DEPTH[Q_PTR_W:0];

    logic [ENTRY_W-1:0] mem [Q_DEPTH];
    logic [Q_PTR_W-1:0] head;
    logic [Q_PTR_W-1:0] tail;
    logic               do_push;
    logic               do_pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push & ~full & ~clear;
    assign do_pop    = pop & ~empty & ~clear;
    assign head_data = mem[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC sequencer around the branch predictor (option: FETCH_PERF_CNT_EN)
`include "diagv2_const.vh"

module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int                Q_DEPTH  = 4,
    parameter int                Q_PTR_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus,
    output logic            q_full,
    output logic            resolve_err,
    output logic [31:0]     ctrl_count,
    output logic [31:0]     mispred_count
);

    logic [DATA_W-1:0]  pc_q;
    logic [ENTRY_W-1:0] head_data;
    logic [DATA_W-1:0]  head_pc;
    logic [DATA_W-1:0]  head_pred;
    logic [Q_PTR_W:0]   q_count;
    logic               q_empty;
    logic               fire;
    logic               flush_c;
    logic               fetch_c;
    logic               err_q;

    assign head_pc   = head_data[`PredQPcMsb:`PredQPcLsb];
    assign head_pred = head_data[`PredQPredMsb:`PredQPredLsb];

    assign fire    = bus.resolve_valid & (q_count != '0);
    assign flush_c = fire & mispredicted(head_pred, bus.resolve_next_pc);
    // Registered full gates fetch, so a pop on a full cycle frees a slot next cycle.
    assign fetch_c = ~bus.stall & ~q_full & ~flush_c;

    assign bus.PC           = pc_q;
    assign bus.fetch_valid  = fetch_c;
    assign bus.flush        = flush_c;
    assign bus.we           = fire & bus.resolve_is_ctrl;
    assign bus.PCUpdate     = fire ? head_pc : '0;
    assign bus.targetUpdate = fire ? bus.resolve_next_pc : '0;
    assign bus.takenUpdate  = fire & bus.resolve_taken;
    assign resolve_err      = err_q;

    pred_queue #(
        .Q_DEPTH (Q_DEPTH),
        .Q_PTR_W (Q_PTR_W)
    ) u_pred_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (fetch_c),
        .push_data ({pc_q, bus.PCPrediction}),
        .pop       (fire),
        .clear     (flush_c),
        .head_data (head_data),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            if (flush_c)      pc_q <= bus.resolve_next_pc;
            else if (fetch_c) pc_q <= bus.PCPrediction;
            if (bus.resolve_valid & q_empty) err_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] ctrl_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (bus.we)  ctrl_cnt_q    <= ctrl_cnt_q + 32'd1;
            if (flush_c) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign ctrl_count    = ctrl_cnt_q;
    assign mispred_count = mispred_cnt_q;
`else
    assign ctrl_count    = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - bench for fetch_pc_unit with a queue-level reference model
module tb_fetch_pc_unit;
    import fetch_pc_unit_pkg::*;

    localparam int          QD  = 4;
    localparam logic [63:0] RPC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        q_full;
    logic        resolve_err;
    logic [31:0] ctrl_count;
    logic [31:0] mispred_count;

    always #5 clk = ~clk;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC (RPC),
        .Q_DEPTH  (QD),
        .Q_PTR_W  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .q_full        (q_full),
        .resolve_err   (resolve_err),
        .ctrl_count    (ctrl_count),
        .mispred_count (mispred_count)
    );

    int checks = 0;
    int errors = 0;

    pq_entry_t   mq[$];
    logic [63:0] m_pc;
    bit          m_err;
    int unsigned m_ctrl;
    int unsigned m_mis;

    logic [63:0] g_pcu;
    logic [63:0] g_tgt;
    logic        g_flush;
    logic        g_we;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] head_pred();
        return (mq.size() != 0) ? mq[0].pred : 64'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc   = RPC;
        m_err  = 1'b0;
        m_ctrl = 0;
        m_mis  = 0;
    endtask

    // One clock: drive, compare against the model at negedge, advance the model at posedge.
    task automatic cyc(input bit st, input bit rv, input bit ctrl, input bit tk,
                       input logic [63:0] npc);
        bit          fire, mis, fv;
        pq_entry_t   h, e;
        logic [63:0] pred;
        pred = m_pc + 64'd4;
        bus.stall           = st;
        bus.PCPrediction    = pred;
        bus.resolve_valid   = rv;
        bus.resolve_is_ctrl = ctrl;
        bus.resolve_taken   = tk;
        bus.resolve_next_pc = npc;
        fire = rv && (mq.size() != 0);
        h    = fire ? mq[0] : '0;
        mis  = fire && (h.pred != npc);
        fv   = !st && (mq.size() < QD) && !mis;
        @(negedge clk);
        chk("pc", bus.PC, m_pc);
        chk("fetch_valid", bus.fetch_valid, fv);
        chk("flush", bus.flush, mis);
        chk("we", bus.we, fire && ctrl);
        chk("q_full", q_full, mq.size() == QD);
        chk("resolve_err", resolve_err, m_err);
        if (fire) begin
            chk("pc_update", bus.PCUpdate, h.pc);
            chk("target_update", bus.targetUpdate, npc);
            chk("taken_update", bus.takenUpdate, tk);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("ctrl_count", ctrl_count, 64'(m_ctrl));
        chk("mispred_count", mispred_count, 64'(m_mis));
`else
        chk("ctrl_count", ctrl_count, 64'h0);
        chk("mispred_count", mispred_count, 64'h0);
`endif
        g_pcu   = bus.PCUpdate;
        g_tgt   = bus.targetUpdate;
        g_flush = bus.flush;
        g_we    = bus.we;
        @(posedge clk);
        if (rv && mq.size() == 0) m_err = 1'b1;
        if (fire) begin
            void'(mq.pop_front());
            if (ctrl) m_ctrl++;
        end
        if (mis) begin
            mq.delete();
            m_mis++;
            m_pc = npc;
        end else if (fv) begin
            e.pc   = m_pc;
            e.pred = pred;
            mq.push_back(e);
            m_pc = pred;
        end
        #1;
    endtask

    initial begin
        reset               = 1'b0;
        bus.stall           = 1'b0;
        bus.PCPrediction    = 64'h4;
        bus.resolve_valid   = 1'b0;
        bus.resolve_is_ctrl = 1'b0;
        bus.resolve_taken   = 1'b0;
        bus.resolve_next_pc = 64'h0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_pc", bus.PC, 64'h0);
        chk("rst_q_full", q_full, 1'b0);
        chk("rst_err", resolve_err, 1'b0);
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_we", bus.we, 1'b0);
        reset = 1'b1;

        // Fill to full: PC 0,4,8,C then hold at 0x10.
        repeat (4) cyc(0, 0, 0, 0, 64'h0);
        chk("pin_pc_full", bus.PC, 64'h10);
        chk("pin_model_pc_full", m_pc, 64'h10);
        chk("pin_q_full", q_full, 1'b1);
        cyc(0, 0, 0, 0, 64'h0);
        chk("pin_pc_hold", bus.PC, 64'h10);

        // Non-control pop on full, then matching ctrl pop alongside a fetch.
        cyc(0, 1, 0, 0, 64'h4);
        cyc(0, 1, 1, 0, 64'h8);
        // Head (0x8, pred 0xC) resolves to 0x100.
        cyc(0, 1, 1, 1, 64'h100);
        chk("pin_flush", g_flush, 1'b1);
        chk("pin_we", g_we, 1'b1);
        chk("pin_pc_update", g_pcu, 64'h8);
        chk("pin_target_update", g_tgt, 64'h100);
        chk("pin_pc_redirect", bus.PC, 64'h100);
        chk("pin_fetch_valid_after", bus.fetch_valid, 1'b1);
        chk("pin_q_after_flush", q_full, 1'b0);

        // Refill, resolve on a full cycle, then steady fetch+resolve across wrap.
        repeat (4) cyc(0, 0, 0, 0, 64'h0);
        cyc(0, 1, 1, 1, head_pred());
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 1, head_pred());
        chk("pin_pc_steady", bus.PC, 64'h138);

        // Drain under stall, then resolve on an empty queue.
        repeat (3) cyc(1, 1, 0, 0, head_pred());
        cyc(1, 1, 1, 1, 64'h40);
        chk("pin_empty_flush", g_flush, 1'b0);
        chk("pin_empty_we", g_we, 1'b0);
        chk("pin_err_set", resolve_err, 1'b1);
        repeat (3) cyc(0, 0, 0, 0, 64'h0);
        chk("pin_err_sticky", resolve_err, 1'b1);

        // Redirect while stalled still loads PC.
        cyc(1, 0, 0, 0, 64'h0);
        cyc(0, 0, 0, 0, 64'h0);
        cyc(1, 1, 1, 1, 64'h200);
        chk("pin_stall_redirect", bus.PC, 64'h200);

        // Asynchronous reset mid-cycle with three entries in flight.
        repeat (3) cyc(0, 0, 0, 0, 64'h0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_pc", bus.PC, RPC);
        chk("async_rst_q_full", q_full, 1'b0);
        chk("async_rst_err", resolve_err, 1'b0);
        chk("async_rst_ctrl", ctrl_count, 64'h0);
        chk("async_rst_mis", mispred_count, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two mispredicts and five control resolves.
        repeat (3) cyc(0, 0, 0, 0, 64'h0);
        cyc(0, 1, 1, 0, 64'h4);
        cyc(0, 1, 1, 1, 64'h200);
        repeat (2) cyc(0, 0, 0, 0, 64'h0);
        cyc(1, 1, 1, 1, 64'h300);
        chk("pin_pc_300", bus.PC, 64'h300);
        repeat (2) cyc(0, 0, 0, 0, 64'h0);
        cyc(0, 1, 1, 0, head_pred());
        cyc(0, 1, 1, 0, head_pred());
        cyc(0, 1, 0, 0, head_pred());
        chk("pin_model_ctrl", 64'(m_ctrl), 64'd5);
        chk("pin_model_mis", 64'(m_mis), 64'd2);
`ifdef FETCH_PERF_CNT_EN
        chk("pin_ctrl_count", ctrl_count, 64'd5);
        chk("pin_mispred_count", mispred_count, 64'd2);
`else
        chk("pin_ctrl_count", ctrl_count, 64'd0);
        chk("pin_mispred_count", mispred_count, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
